// File: rtl/fat32_bpb_reader.sv
// fat32_bpb_reader
//
// Parses FAT32 sector 0 (boot sector / BPB) as it streams out of the SD-card
// sector reader. It captures the volume geometry fields and checks the boot
// signature. It then derives the absolute FAT, data-region and root-directory
// sector addresses. The multiplies are done as an 8-step shift-add.
//
// Optional feature macro: BPB_READER_CHECK_GEOMETRY_EN
//   defined   : BytsPerSec, SecPerClus, NumFATs and FATSz32 are sanity-checked
//               and a failure reports error code 10.
//   undefined : only the signature and RootClus checks apply.
//
// Ports
//   clk                  system clock, rising edge
//   sys_rst_n            asynchronous active-low reset
//   start                one-cycle pulse, arms parsing of the next sector
//   base_lba[31:0]       partition start sector, sampled on accepted start
//   byte_valid           byte_data valid this cycle (no backpressure)
//   byte_data[7:0]       sector byte, offset 0 first
//   busy                 high from accepted start until done
//   done                 one-cycle completion pulse
//   error                valid with done, held until next accepted start
//   error_code[1:0]      00 ok, 01 bad signature, 10 bad geometry, 11 RootClus<2
//   reserved_sectors     BPB offset 14-15
//   num_fats             BPB offset 16
//   sectors_per_cluster  BPB offset 13
//   fat_size             FATSz32, offset 36-39
//   root_cluster         RootClus, offset 44-47
//   fat_start_sector     base_lba + reserved_sectors
//   data_start_sector    fat_start_sector + num_fats*fat_size
//   root_dir_sector      data_start_sector + (root_cluster-2)*sectors_per_cluster
//   dbg_state[2:0]       current FSM state (IDLE=0 RECV=1 CHECK=2 CALC=3 FINISH=4)
//
// Handshake: the byte stream has no backpressure. A byte is consumed on every
// rising edge where byte_valid=1 while the block is in RECV. start is accepted
// only in IDLE and only when done is not high, so the done cycle never also
// accepts a new start.

module fat32_bpb_reader #(
  parameter int SECTOR_BYTES = 512
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [31:0] base_lba,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  error_code,
  output logic [15:0] reserved_sectors,
  output logic [7:0]  num_fats,
  output logic [7:0]  sectors_per_cluster,
  output logic [31:0] fat_size,
  output logic [31:0] root_cluster,
  output logic [31:0] fat_start_sector,
  output logic [31:0] data_start_sector,
  output logic [31:0] root_dir_sector,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECV   = 3'd1,
    S_CHECK  = 3'd2,
    S_CALC   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [15:0] LAST_BYTE = 16'(SECTOR_BYTES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [31:0] base_q;
  logic [7:0]  sig0_q;
  logic [7:0]  sig1_q;
  logic [1:0]  code_q;
  logic [2:0]  step_q;
  logic [31:0] acc_fat_q;
  logic [31:0] acc_root_q;
`ifdef BPB_READER_CHECK_GEOMETRY_EN
  logic [15:0] bps_q;
`endif

  logic        geom_bad_d;
  logic [1:0]  code_d;
  logic [31:0] root_m2_d;
  logic [31:0] fat_term_d;
  logic [31:0] root_term_d;
  logic [31:0] fat_start_d;
  logic [31:0] data_start_d;
  logic [31:0] root_dir_d;

  assign dbg_state = state_q;

`ifdef BPB_READER_CHECK_GEOMETRY_EN
  // A power of two has exactly one bit set: x & (x-1) clears the lowest bit.
  assign geom_bad_d = (bps_q != 16'(SECTOR_BYTES)) ||
                      (sectors_per_cluster == 8'd0) ||
                      ((sectors_per_cluster & (sectors_per_cluster - 8'd1)) != 8'd0) ||
                      (num_fats == 8'd0) ||
                      (fat_size == 32'd0);
`else
  assign geom_bad_d = 1'b0;
`endif

  // Checks are evaluated in priority order: signature, geometry, RootClus.
  always_comb begin
    code_d = 2'b00;
    if (sig0_q != 8'h55 || sig1_q != 8'hAA) begin
      code_d = 2'b01;
    end else if (geom_bad_d) begin
      code_d = 2'b10;
    end else if (root_cluster < 32'd2) begin
      code_d = 2'b11;
    end
  end

  // One partial product per CALC cycle, selected by the multiplier bit at step_q.
  assign root_m2_d   = root_cluster - 32'd2;
  assign fat_term_d  = num_fats[step_q]            ? (fat_size  << step_q) : 32'd0;
  assign root_term_d = sectors_per_cluster[step_q] ? (root_m2_d << step_q) : 32'd0;

  assign fat_start_d  = base_q + {16'h0000, reserved_sectors};
  assign data_start_d = fat_start_d + acc_fat_q;
  assign root_dir_d   = data_start_d + acc_root_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q             <= S_IDLE;
      cnt_q               <= 16'd0;
      base_q              <= 32'd0;
      sig0_q              <= 8'd0;
      sig1_q              <= 8'd0;
      code_q              <= 2'b00;
      step_q              <= 3'd0;
      acc_fat_q           <= 32'd0;
      acc_root_q          <= 32'd0;
`ifdef BPB_READER_CHECK_GEOMETRY_EN
      bps_q               <= 16'd0;
`endif
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
      error_code          <= 2'b00;
      reserved_sectors    <= 16'd0;
      num_fats            <= 8'd0;
      sectors_per_cluster <= 8'd0;
      fat_size            <= 32'd0;
      root_cluster        <= 32'd0;
      fat_start_sector    <= 32'd0;
      data_start_sector   <= 32'd0;
      root_dir_sector     <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // done is high only on the cycle after FINISH; block start there.
          if (start && !done) begin
            base_q     <= base_lba;
            cnt_q      <= 16'd0;
            error      <= 1'b0;
            error_code <= 2'b00;
            busy       <= 1'b1;
            state_q    <= S_RECV;
          end
        end

        S_RECV: begin
          if (byte_valid) begin
            case (cnt_q)
`ifdef BPB_READER_CHECK_GEOMETRY_EN
              16'd11:  bps_q[7:0]            <= byte_data;
              16'd12:  bps_q[15:8]           <= byte_data;
`endif
              16'd13:  sectors_per_cluster   <= byte_data;
              16'd14:  reserved_sectors[7:0] <= byte_data;
              16'd15:  reserved_sectors[15:8] <= byte_data;
              16'd16:  num_fats              <= byte_data;
              16'd36:  fat_size[7:0]         <= byte_data;
              16'd37:  fat_size[15:8]        <= byte_data;
              16'd38:  fat_size[23:16]       <= byte_data;
              16'd39:  fat_size[31:24]       <= byte_data;
              16'd44:  root_cluster[7:0]     <= byte_data;
              16'd45:  root_cluster[15:8]    <= byte_data;
              16'd46:  root_cluster[23:16]   <= byte_data;
              16'd47:  root_cluster[31:24]   <= byte_data;
              16'd510: sig0_q                <= byte_data;
              16'd511: sig1_q                <= byte_data;
              default: ;
            endcase
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == LAST_BYTE) begin
              state_q <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          code_q     <= code_d;
          step_q     <= 3'd0;
          acc_fat_q  <= 32'd0;
          acc_root_q <= 32'd0;
          state_q    <= (code_d != 2'b00) ? S_FINISH : S_CALC;
        end

        S_CALC: begin
          acc_fat_q  <= acc_fat_q + fat_term_d;
          acc_root_q <= acc_root_q + root_term_d;
          step_q     <= step_q + 3'd1;
          if (step_q == 3'd7) begin
            state_q <= S_FINISH;
          end
        end

        S_FINISH: begin
          // On error the sector outputs keep the last successful result.
          if (code_q == 2'b00) begin
            fat_start_sector  <= fat_start_d;
            data_start_sector <= data_start_d;
            root_dir_sector   <= root_dir_d;
          end
          error      <= (code_q != 2'b00);
          error_code <= code_q;
          done       <= 1'b1;
          busy       <= 1'b0;
          state_q    <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
